// File: rtl/brush_stroke_writer.sv
// Brush stroke framebuffer writer: stamps a clamped square brush one pixel per cycle
// and performs full-frame clears. Define BRUSH_ROUND_EN to drop the corners of stamps >= 3.
module brush_stroke_writer #(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int PIXEL_W   = 1,
  parameter int ADDR_W    = 19,
  parameter int BRUSH_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pos_valid,
  input  logic [9:0]         pos_x,
  input  logic [9:0]         pos_y,
  input  logic               draw,
  input  logic               erase,
  input  logic [3:0]         brush_size,
  input  logic [PIXEL_W-1:0] color,
  input  logic               clear_req,
  output logic               ready,
  output logic               write_enable,
  output logic [ADDR_W-1:0]  write_addr,
  output logic [PIXEL_W-1:0] write_data,
  output logic               clear_done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StPaint = 2'd1;
  localparam logic [1:0] StClear = 2'd2;

  localparam int                AW1       = ADDR_W + 1;
  localparam logic [10:0]       HRes11    = 11'(H_RES);
  localparam logic [10:0]       VRes11    = 11'(V_RES);
  localparam logic [3:0]        BrushMax  = 4'(BRUSH_MAX);
  localparam logic [ADDR_W-1:0] FrameLast = ADDR_W'(H_RES * V_RES - 1);

  logic [1:0]         state_q, state_d;
  logic [9:0]         x_q, x_d, y_q, y_d;
  logic [3:0]         size_q, size_d, dx_q, dx_d, dy_q, dy_d;
  logic [PIXEL_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;
  logic               we_q, we_d, done_q, done_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [PIXEL_W-1:0] wdata_q, wdata_d;

  logic [10:0]  px, py;
  logic [AW1-1:0] paint_addr;
  logic [3:0]   last_idx, size_clamped;
  logic         clipped, corner;

  assign px         = {1'b0, x_q} + {7'b0, dx_q};
  assign py         = {1'b0, y_q} + {7'b0, dy_q};
  assign paint_addr = AW1'(py) * AW1'(H_RES) + AW1'(px);
  assign last_idx   = size_q - 4'd1;
  // The address MSB can only be set for off-screen pixels; treat it as a clip too.
  assign clipped    = (px >= HRes11) || (py >= VRes11) || paint_addr[ADDR_W];

  always_comb begin
    size_clamped = brush_size;
    if (brush_size == 4'd0) begin
      size_clamped = 4'd1;
    end else if (brush_size > BrushMax) begin
      size_clamped = BrushMax;
    end
  end

`ifdef BRUSH_ROUND_EN
  assign corner = (size_q >= 4'd3) && ((dx_q == 4'd0) || (dx_q == last_idx)) &&
                  ((dy_q == 4'd0) || (dy_q == last_idx));
`else
  assign corner = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    size_d     = size_q;
    data_d     = data_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    clr_addr_d = clr_addr_q;
    we_d       = 1'b0;
    done_d     = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d    = StClear;
          clr_addr_d = '0;
        end else if (pos_valid && (draw || erase)) begin
          state_d = StPaint;
          x_d     = pos_x;
          y_d     = pos_y;
          size_d  = size_clamped;
          data_d  = draw ? color : '0;
          dx_d    = 4'd0;
          dy_d    = 4'd0;
        end
      end
      StPaint: begin
        if (!clipped && !corner) begin
          we_d    = 1'b1;
          addr_d  = paint_addr[ADDR_W-1:0];
          wdata_d = data_q;
        end
        if (dx_q == last_idx) begin
          dx_d = 4'd0;
          if (dy_q == last_idx) begin
            state_d = StIdle;
          end else begin
            dy_d = dy_q + 4'd1;
          end
        end else begin
          dx_d = dx_q + 4'd1;
        end
      end
      StClear: begin
        we_d    = 1'b1;
        addr_d  = clr_addr_q;
        wdata_d = '0;
        if (clr_addr_q == FrameLast) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      x_q        <= '0;
      y_q        <= '0;
      size_q     <= '0;
      data_q     <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      clr_addr_q <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      size_q     <= size_d;
      data_q     <= data_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      clr_addr_q <= clr_addr_d;
      we_q       <= we_d;
      done_q     <= done_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign ready        = (state_q == StIdle);
  assign write_enable = we_q;
  assign write_addr   = addr_q;
  assign write_data   = wdata_q;
  assign clear_done   = done_q;

endmodule

// File: doc/brush_stroke_writer.md
Name: brush_stroke_writer

Overview:
- Next-generation framebuffer writer for the mouse paint design; replaces the single-pixel mouse-to-memory path.
- Accepts mouse position samples with draw/erase buttons. Stamps a square brush of run-time-selectable size and colour into the dual-port frame memory (port A), one pixel per cycle.
- Also performs a full-screen clear sweep on request.
- Sits between the mouse controller and the framebuffer block RAM, in the 25 MHz pixel clock domain.

Parameters:
- H_RES, 640, visible width in pixels; row pitch of the framebuffer.
- V_RES, 480, visible height in pixels.
- PIXEL_W, 1, bits per stored pixel.
- ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES.
- BRUSH_MAX, 8, largest brush edge in pixels (1..15).

Ports:
- clk  input  1  pixel-domain clock (25 MHz).
- rst  input  1  synchronous, active-high reset.
- pos_valid  input  1  new mouse sample present this cycle.
- pos_x  input  10  sample X; top-left corner of the brush.
- pos_y  input  10  sample Y; top-left corner of the brush.
- draw  input  1  left button; paint with colour.
- erase  input  1  right button; paint with 0.
- brush_size  input  4  requested brush edge.
- color  input  PIXEL_W  draw colour.
- clear_req  input  1  request a full-frame clear.
- ready  output  1  block is idle and will accept a sample or clear this cycle.
- write_enable  output  1  framebuffer port-A write strobe.
- write_addr  output  ADDR_W  framebuffer port-A address.
- write_data  output  PIXEL_W  framebuffer port-A data.
- clear_done  output  1  single-cycle pulse when a clear finishes.

Behaviour:
- Reset values:
  - state IDLE; ready=1.
  - write_enable=0, write_addr=0, write_data=0, clear_done=0.
  - All internal counters 0.
- Reset mid-paint or mid-clear aborts immediately. No further writes; clear_done does not pulse.
- ready = (state==IDLE), combinational from state. Samples with ready=0 are dropped; there is no queuing.
- States: IDLE, PAINT, CLEAR.
- IDLE, evaluated in priority order at a clock edge:
  1. clear_req=1 -> go to CLEAR. Any simultaneous pos_valid is dropped.
  2. pos_valid && (draw||erase) -> latch x, y, size and data; go to PAINT.
  3. pos_valid with neither button -> ignored; stay in IDLE.
- Size latching: brush_size is clamped to 1..BRUSH_MAX (0 becomes 1; values above BRUSH_MAX become BRUSH_MAX). n = size*size.
- Data latching: data = draw ? color : 0. draw wins if draw and erase are both set.
- PAINT scan:
  - Visits one (dx,dy) per cycle, row-major with dx inner. Both run 0..size-1.
  - Pixel address = (y+dy)*H_RES + (x+dx), computed at ADDR_W+1 bits with no wrap.
  - Pixels with x+dx >= H_RES or y+dy >= V_RES are clipped: the cycle is consumed with write_enable=0 and write_addr/write_data hold their previous values.
  - Inputs are ignored for the whole stroke.
- PAINT timing, with E0 the accept edge:
  - Pixel k (k=0..n-1) is registered at edge E0+k+1 and is visible until edge E0+k+2.
  - State returns to IDLE at edge E0+n, so ready is low for exactly n cycles.
  - Earliest next accept is edge E0+n+1.
- CLEAR:
  - Writes addresses 0..H_RES*V_RES-1 in order, one per cycle, write_data=0, write_enable=1.
  - clear_done pulses high for one cycle, coincident with the final write's output cycle. State then returns to IDLE.
  - clear_req is ignored during CLEAR.
- write_enable is 0 in every cycle not listed above.

Optional Feature:
- Macro: BRUSH_ROUND_EN.
- When defined: for size >= 3, the four corner pixels of each stamp are suppressed (write_enable=0), approximating a round brush.
  - Suppressed pixels: (0,0), (size-1,0), (0,size-1), (size-1,size-1).
  - Cycle count and ready timing are unchanged.
  - Sizes 1 and 2 are unaffected.
- When undefined: full square brush; no corner logic is synthesised.

Test Plan:
- Single draw: reset; pos=(10,20), draw=1, brush_size=1, color=1, pos_valid for 1 cycle -> exactly one write to address 12810 with data 1; ready low for 1 cycle.
- 3x3 stamp: pos=(100,50), brush_size=3, draw -> 9 consecutive writes at 32100, 32101, 32102, 32740 … 33382; ready back high after 9 cycles.
- Clipping and erase: pos=(638,479), brush_size=4, erase=1, color=1 -> 16 cycles; writes only at 307198 and 307199 with data 0; other cycles write_enable=0.
- Clamp and priority: brush_size=0 -> 1 write; brush_size=15 with BRUSH_MAX=8 -> 64 cycles; draw and erase both set -> data equals color; pos_valid during PAINT -> no extra writes.
- Clear: clear_req and pos_valid together -> 307200 writes of 0 at addresses 0..307199; clear_done single pulse on the last write; no paint follows.
- Reset mid-stroke: assert rst on pixel 5 of an 8x8 stamp -> next cycle write_enable=0, ready=1, no further writes. With BRUSH_ROUND_EN, a 3x3 stamp at (0,0) writes only addresses 1, 640, 641, 642, 1281.
